// File: rtl/lms_pkg.sv
// Shared definitions for the LMS error/MAC stage and the weight-update stage:
// widths, FSM state encoding and the DW-bit saturation helper.
package lms_pkg;

  localparam int NTAP = 32;               // number of taps (power of two)
  localparam int DW   = 14;               // sample / desired / error width
  localparam int WW   = 32;               // weight width
  localparam int FRAC = 16;               // weight fractional bits
  localparam int IW   = $clog2(NTAP);     // tap index width
  localparam int ACCW = WW + DW + IW;     // accumulator width, cannot overflow

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic signed [ACCW:0] SAT_HI = (ACCW+1)'(2**(DW-1) - 1);
  localparam logic signed [ACCW:0] SAT_LO = (ACCW+1)'(-(2**(DW-1)));

  // Clamp a wide signed value into the DW-bit two's complement range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW:0] v);
    if (v > SAT_HI)
      sat_dw = {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_LO)
      sat_dw = {1'b1, {(DW-1){1'b0}}};
    else
      sat_dw = v[DW-1:0];
  endfunction

endpackage

// File: rtl/lms_tap_line.sv
// Reference delay line: NTAP samples of DW bits, shifted on shift_en.
// Tap i is presented at taps_flat[i*DW +: DW]; tap 0 is the newest sample.
module lms_tap_line #(
  parameter int NTAP = lms_pkg::NTAP,
  parameter int DW   = lms_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [DW-1:0]        x_in,
  output logic [NTAP*DW-1:0]   taps_flat
);

  // Shift the newest sample into tap 0, everything else moves up one tap.
  always_ff @(posedge clk) begin
    if (rst)
      taps_flat <= '0;
    else if (shift_en)
      taps_flat <= {taps_flat[(NTAP-1)*DW-1:0], x_in};
  end

endmodule

// File: rtl/lms_error_mac.sv
// LMS error stage: keeps the reference delay line, computes y = sum(w_i*x_i)
// with one multiplier over NTAP cycles (weights read one per cycle through
// weight_addr/weight_rdata) and outputs the saturated error e = d - y.
// Build option: define LMS_ROUND_EN to round y half-up instead of flooring.
module lms_error_mac
  import lms_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [DW-1:0]       x_in,
  input  logic [DW-1:0]       d_in,
  output logic [IW-1:0]       weight_addr,
  input  logic [WW-1:0]       weight_rdata,
  output logic [NTAP*DW-1:0]  reff_flat,
  output logic [DW-1:0]       e,
  output logic                e_valid,
  output logic                busy,
  output logic                overrun
);

`ifdef LMS_ROUND_EN
  localparam logic signed [ACCW:0] HALF_LSB = (ACCW+1)'(1) <<< (FRAC-1);
`endif

  // Bring the accumulator back to sample scale (floor, or round half up).
  function automatic logic signed [ACCW:0] scale_acc(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] v;
    v = (ACCW+1)'(a);
`ifdef LMS_ROUND_EN
    v = v + HALF_LSB;
`endif
    return v >>> FRAC;
  endfunction

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q;
  logic signed [DW-1:0]    d_q;
  logic signed [ACCW-1:0]  acc_q;
  logic                    accept;
  logic                    last_tap;
  logic signed [DW-1:0]    tap_sel_p0;
  logic signed [WW+DW-1:0] prod_p0;
  logic signed [ACCW:0]    y_p1;
  logic signed [ACCW:0]    diff_p1;

  // A sample is only taken when the engine is idle; anything else is an overrun.
  assign accept   = (state_q == IDLE) && sample_valid;
  assign last_tap = (idx_q == IW'(NTAP-1));

  lms_tap_line #(
    .NTAP (NTAP),
    .DW   (DW)
  ) u_tap_line (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (accept),
    .x_in      (x_in),
    .taps_flat (reff_flat)
  );

  // --- MAC stage: select tap[idx] and multiply by the weight read this cycle ---
  always_comb begin
    tap_sel_p0 = '0;
    for (int i = 0; i < NTAP; i++)
      if (idx_q == IW'(i))
        tap_sel_p0 = reff_flat[i*DW +: DW];
    prod_p0 = $signed(weight_rdata) * tap_sel_p0;
  end

  // --- ERR stage: rescale the sum and subtract from the latched desired sample ---
  always_comb begin
    y_p1    = scale_acc(acc_q);
    diff_p1 = (ACCW+1)'(d_q) - y_p1;
  end

  assign weight_addr = (state_q == MAC) ? idx_q : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next-state: IDLE -> MAC on accept, MAC for NTAP cycles, ERR for one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_valid) state_d = MAC;
      MAC:     if (last_tap)     state_d = ERR;
      ERR:                       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Datapath and status: accumulate during MAC, publish e at the end of ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      e       <= '0;
      e_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      e_valid <= 1'b0;
      if (sample_valid && (state_q != IDLE))
        overrun <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (sample_valid) begin
            d_q   <= $signed(d_in);
            acc_q <= '0;
            idx_q <= '0;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACCW'(prod_p0);
          if (!last_tap)
            idx_q <= idx_q + 1'b1;
        end
        ERR: begin
          e       <= sat_dw(diff_p1);
          e_valid <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_error_mac.sv
// Self-checking bench for lms_error_mac: directed cases for gain, saturation,
// rounding, delay line, overrun and mid-operation reset, then random samples
// checked against a plain-arithmetic model of the filter.
module tb_lms_error_mac;
  import lms_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [DW-1:0]     x_in = '0;
  logic [DW-1:0]     d_in = '0;
  logic [IW-1:0]     weight_addr;
  logic [WW-1:0]     weight_rdata;
  logic [NTAP*DW-1:0] reff_flat;
  logic [DW-1:0]     e;
  logic              e_valid;
  logic              busy;
  logic              overrun;

  logic signed [WW-1:0] wmem [NTAP];
  int mtap [NTAP];
  int md;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign weight_rdata = wmem[weight_addr];

  lms_error_mac dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .d_in         (d_in),
    .weight_addr  (weight_addr),
    .weight_rdata (weight_rdata),
    .reff_flat    (reff_flat),
    .e            (e),
    .e_valid      (e_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int tap_of(input int i);
    logic signed [DW-1:0] t;
    t = reff_flat[i*DW +: DW];
    return int'(t);
  endfunction

  // Reference: dot product of weights and taps, rescale, subtract, clamp.
  function automatic int model_e();
    longint acc = 0;
    longint y;
    longint diff;
    for (int i = 0; i < NTAP; i++)
      acc += longint'(wmem[i]) * longint'(mtap[i]);
`ifdef LMS_ROUND_EN
    acc += longint'(1) << (FRAC-1);
`endif
    y    = acc >>> FRAC;
    diff = longint'(md) - y;
    if (diff > 8191)  return 8191;
    if (diff < -8192) return -8192;
    return int'(diff);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NTAP; i++) mtap[i] = 0;
    md = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic set_weights_zero();
    for (int i = 0; i < NTAP; i++) wmem[i] = '0;
  endtask

  task automatic set_weights_random();
    for (int i = 0; i < NTAP; i++)
      wmem[i] = int'($urandom_range(0, 32767)) - 16384;
  endtask

  // Pulse sample_valid for one cycle; returns at the start of cycle T+1.
  task automatic apply(input int x, input int d);
    sample_valid = 1'b1;
    x_in = DW'(x);
    d_in = DW'(d);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    for (int i = NTAP-1; i > 0; i--) mtap[i] = mtap[i-1];
    mtap[0] = x;
    md = d;
  endtask

  // Wait (bounded) for e_valid, then check latency, e and busy.
  task automatic await_e(input string tag, input int want_lat);
    int n;
    int want;
    n = 0;
    want = model_e();
    while (!e_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, want_lat);
    chk({tag, "_e"}, int'($signed(e)), want);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int seen;
    set_weights_zero();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_e", e, 0);
    chk("rst_evalid", e_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", weight_addr, 0);
    chk("rst_taps", (reff_flat == '0), 1);

    // Unit gain
    wmem[0] = 65536;
    apply(100, 150);
    chk("unit_tap0", tap_of(0), 100);
    chk("unit_busy_hi", busy, 1);
    chk("unit_addr0", weight_addr, 0);
    await_e("unit", 33);
    chk("unit_e_lit", int'($signed(e)), 50);
    chk("unit_addr_idle", weight_addr, 0);
    @(posedge clk);
    #1;
    chk("unit_pulse", e_valid, 0);
    chk("unit_hold", int'($signed(e)), 50);

    // Saturation both ways
    wmem[0] = -262144;
    apply(4000, 0);
    await_e("satp", 33);
    chk("satp_lit", int'($signed(e)), 8191);
    wmem[0] = 262144;
    apply(4000, 0);
    await_e("satn", 33);
    chk("satn_lit", int'($signed(e)), -8192);

    // Rounding of +/-1.5
    wmem[0] = 32768;
    apply(3, 0);
    await_e("rndp", 33);
`ifdef LMS_ROUND_EN
    chk("rndp_lit", int'($signed(e)), -2);
`else
    chk("rndp_lit", int'($signed(e)), -1);
`endif
    apply(-3, 0);
    await_e("rndn", 33);
`ifdef LMS_ROUND_EN
    chk("rndn_lit", int'($signed(e)), 1);
`else
    chk("rndn_lit", int'($signed(e)), 2);
`endif

    // Reset in the middle of a MAC run
    wmem[0] = -262144;
    apply(1000, 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    chk("mrst_busy", busy, 0);
    chk("mrst_taps", (reff_flat == '0), 1);
    chk("mrst_addr", weight_addr, 0);
    chk("mrst_e", e, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (e_valid) seen++;
    end
    chk("mrst_no_evalid", seen, 0);

    // Overrun: second strobe at T+5 is dropped
    set_weights_random();
    apply(500, 20);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b1;
    x_in = DW'(777);
    d_in = DW'(-300);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_tap0", tap_of(0), 500);
    chk("ovr_tap1", tap_of(1), 0);
    await_e("ovr", 28);
    chk("ovr_sticky", overrun, 1);
    do_reset();
    chk("ovr_cleared", overrun, 0);

    // Delay line: 33 back-to-back samples, each issued on the e_valid cycle
    set_weights_random();
    for (int k = 1; k <= 33; k++) begin
      apply(k, int'($urandom_range(0, 16383)) - 8192);
      await_e("dline", 33);
    end
    chk("dline_tap0", tap_of(0), 33);
    chk("dline_tap31", tap_of(NTAP-1), 2);
    chk("dline_overrun", overrun, 0);

    // Random samples with random weights and gaps
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) set_weights_random();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      apply(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      await_e("rand", 33);
      chk("rand_tap0", tap_of(0), mtap[0]);
      chk("rand_tapN", tap_of(NTAP-1), mtap[NTAP-1]);
    end
    chk("rand_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
